// File: rtl/mux_8to1.sv
// 8-to-1 lane multiplexer built from two 4:1 stages and a 2:1 stage, with a
// combinational result and a registered, enable-qualified result plus valid flag.
module mux_8to1 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*WIDTH-1:0] in,
    input  logic [2:0]         sel,
    input  logic               en,
    output logic [WIDTH-1:0]   y_comb,
    output logic [WIDTH-1:0]   y,
    output logic               y_valid
);

    logic [WIDTH-1:0] w_lane [8];
    logic [WIDTH-1:0] w_stage_a;
    logic [WIDTH-1:0] w_stage_b;
    logic [WIDTH-1:0] w_sel_lane;
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;

    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign w_lane[i] = in[i*WIDTH +: WIDTH];
    end

    // NOTE: every case below covers all four codes of sel[1:0], so each output
    // is written on every path and no latch can be inferred.
    always_comb begin
        unique case (sel[1:0])
            2'd0: w_stage_a = w_lane[0];
            2'd1: w_stage_a = w_lane[1];
            2'd2: w_stage_a = w_lane[2];
            2'd3: w_stage_a = w_lane[3];
        endcase
    end

    always_comb begin
        unique case (sel[1:0])
            2'd0: w_stage_b = w_lane[4];
            2'd1: w_stage_b = w_lane[5];
            2'd2: w_stage_b = w_lane[6];
            2'd3: w_stage_b = w_lane[7];
        endcase
    end

    assign w_sel_lane = sel[2] ? w_stage_b : w_stage_a;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else if (en) begin
            r_y       <= w_sel_lane;
            r_y_valid <= 1'b1;
        end else begin
            r_y_valid <= 1'b0;
        end
    end

    assign y_comb  = w_sel_lane;
    assign y       = r_y;
    assign y_valid = r_y_valid;

endmodule

// File: tb/tb_mux_8to1.sv
// Self-checking bench for mux_8to1: a WIDTH=1 and a WIDTH=8 instance share
// sel/en/rst; registered expectations flow through a scoreboard queue.
module tb_mux_8to1;

    typedef struct packed {
        logic       y1;
        logic [7:0] y8;
        logic       v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in1 = '0;
    logic [63:0] in8 = '0;
    logic [2:0]  sel = '0;
    logic        en  = 1'b0;
    logic        y_comb1, y1, y_valid1;
    logic [7:0]  y_comb8, y8;
    logic        y_valid8;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    logic       m_y1 = 1'b0;
    logic [7:0] m_y8 = 8'h00;

    localparam logic [63:0] LANES8 = 64'h7766_5544_3322_1100;

    mux_8to1 #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in(in1), .sel(sel), .en(en),
        .y_comb(y_comb1), .y(y1), .y_valid(y_valid1)
    );

    mux_8to1 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in(in8), .sel(sel), .en(en),
        .y_comb(y_comb8), .y(y8), .y_valid(y_valid8)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lane8(input logic [63:0] v, input logic [2:0] s);
        return v[s*8 +: 8];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational path, queue the
    // expected registered result, then compare it after the capturing edge.
    task automatic step(input logic [7:0] a1, input logic [63:0] a8,
                        input logic [2:0] s, input logic e, input logic r);
        exp_t ex;
        @(negedge clk);
        in1 = a1; in8 = a8; sel = s; en = e; rst = r;
        #1;
        check("y_comb_w1", {7'b0, y_comb1}, {7'b0, a1[s]});
        check("y_comb_w8", y_comb8, lane8(a8, s));
        if (r) begin
            m_y1 = 1'b0; m_y8 = 8'h00; ex.v = 1'b0;
        end else if (e) begin
            m_y1 = a1[s]; m_y8 = lane8(a8, s); ex.v = 1'b1;
        end else begin
            ex.v = 1'b0;
        end
        ex.y1 = m_y1;
        ex.y8 = m_y8;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        ex = sb_q.pop_front();
        check("y_w1", {7'b0, y1}, {7'b0, ex.y1});
        check("y_w8", y8, ex.y8);
        check("y_valid_w1", {7'b0, y_valid1}, {7'b0, ex.v});
        check("y_valid_w8", {7'b0, y_valid8}, {7'b0, ex.v});
    endtask

    initial begin
        // Reset held two cycles with en=1: outputs stay cleared, then first capture.
        step(8'hFF, LANES8, 3'b001, 1'b1, 1'b1);
        step(8'hFF, LANES8, 3'b001, 1'b1, 1'b1);
        step(8'hFF, LANES8, 3'b001, 1'b1, 1'b0);

        // Sweep with en=0: combinational only, registered value holds.
        for (int i = 0; i < 8; i++) step(8'b1010_1010, LANES8, 3'(i), 1'b0, 1'b0);

        // Sweep with en=1: y follows one edge later, valid stays high.
        for (int i = 0; i < 8; i++) step(8'b1010_1010, LANES8, 3'(i), 1'b1, 1'b0);

        // Hold: capture lane 7, then drop en and clear inputs.
        step(8'h80, 64'hA500_0000_0000_0000, 3'b111, 1'b1, 1'b0);
        step(8'h00, 64'h0, 3'b111, 1'b0, 1'b0);
        step(8'h00, 64'h0, 3'b111, 1'b0, 1'b0);

        // Randomised cycles against the behavioural model.
        for (int i = 0; i < 1000; i++) begin
            step(8'($urandom), {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_8to1.md
Name: mux_8to1

Overview:
8-to-1 multiplexer that selects one of eight WIDTH-bit lanes packed into a single input bus using a 3-bit select. It is built hierarchically from two 4-to-1 stages and a final 2-to-1 stage. It provides a combinational result and a registered, enable-qualified result with a valid flag. It sits in data-routing paths wherever a lane must be picked by a binary index.

Parameters:
WIDTH, 1, bit width of each lane and of both outputs

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in  input  8*WIDTH  packed lanes; lane i = in[i*WIDTH +: WIDTH], lane 0 at LSBs
sel  input  3  binary lane index 0..7
en  input  1  capture enable for registered output
y_comb  output  WIDTH  combinational selected lane
y  output  WIDTH  registered selected lane
y_valid  output  1  high for the cycle after a capture

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. It is sampled only on the rising edge of clk; there is no asynchronous path.
- Combinational path:
  - y_comb = lane[sel] at all times, with no clock dependence.
  - Any change on in or sel propagates within the same delta/cycle.
- Structure:
  - Stage A (4:1) selects among lanes 0-3 using sel[1:0].
  - Stage B (4:1) selects among lanes 4-7 using sel[1:0].
  - The final 2:1 stage picks A when sel[2]=0 and B when sel[2]=1.
  - The result must equal a flat lane[sel] for all 8 codes.
- Registered path, on each rising clk edge:
  - If rst=1: y <= 0, y_valid <= 0. rst has priority over en.
  - Else if en=1: y <= lane[sel] (same value as y_comb at the edge), y_valid <= 1.
  - Else: y holds its previous value, y_valid <= 0.
- Latency: y reflects the lane selected at the capturing edge, one cycle after en is sampled high. y_valid is a one-cycle pulse per capture.
- Back-to-back en=1 keeps y_valid high continuously, and y updates every cycle.
- Reset mid-operation: rst=1 together with en=1 leaves y=0 and y_valid=0. The first capture after reset release happens at the first edge with rst=0 and en=1.
- Power-up: y and y_valid are undefined until the first reset edge. y_comb is valid immediately.
- X/Z on sel: no requirement beyond what the simulator produces. All 8 codes are legal, so there is no default/error case.
- No internal state other than y and y_valid.

Test Plan:
- WIDTH=1, in=8'b10101010, en=0, sweep sel 0..7 at 10 ns each -> y_comb = 0,1,0,1,0,1,0,1.
- Same stimulus with en=1 -> one edge after each sel change, y = 0,1,0,1,0,1,0,1 and y_valid stays 1 throughout.
- rst=1 for 2 cycles with en=1, sel=3'b001, in=8'hFF -> y=0, y_valid=0. One cycle after rst drops, y=1 and y_valid=1.
- Hold test: capture sel=3'b111 with in=8'h80 (y=1), then en=0 and change in=8'h00 -> y stays 1, y_valid=0, y_comb=0.
- WIDTH=8, in = lanes 0x00,0x11,...,0x77 (lane i = 0x11*i), sweep sel 0..7 with en=1 -> y = 0x11*sel, one cycle late. This checks the boundary codes sel=3 (A->B split at 3/4) and sel=7.
- Random: 1000 cycles of random in, sel, en, rst -> y_comb, y and y_valid match a behavioural reference model every cycle.
